// File: rtl/burst_read_sched.sv
// Burst read scheduler: splits a beat-count read command into AXI INCR bursts
// that never cross a 4 KB boundary and never overrun the consumer FIFO.
module burst_read_sched #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned DATA_COUNT_WIDTH   = 9,
    parameter int unsigned MAX_DATA_COUNT     = 256,
    parameter int unsigned MAX_BURST          = 16,
    parameter int unsigned LEN_WIDTH          = 16
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]          cmd_beats,
    input  logic [DATA_COUNT_WIDTH-1:0]   data_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic                          rbeat,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned AW  = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned LW  = LEN_WIDTH;
    localparam int unsigned BPB = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned SZ  = $clog2(BPB);
    localparam int unsigned OW  = DATA_COUNT_WIDTH + 1;
    localparam int unsigned SW  = DATA_COUNT_WIDTH + 2;
    localparam int unsigned MW  = (LW > 13) ? LW : 13;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t         r_state;
    logic [AW-1:0]  r_addr;
    logic [LW-1:0]  r_rem;
    logic [8:0]     r_blen;
    logic [OW-1:0]  r_outstanding;
    logic [AW-1:0]  r_araddr;
    logic [7:0]     r_arlen;
    logic           r_arvalid;
    logic           r_done;
    logic           r_err;
    logic           r_busy;
    logic           r_cmd_ready;

    logic [12:0]          w_b4k;
    logic [MW-1:0]        w_lim;
    logic [MW-1:0]        w_min;
    logic [8:0]           w_blen_calc;
    logic signed [SW-1:0] w_space;
    logic                 w_space_ok;
    logic                 w_hs;
    logic                 w_spurious;
    logic                 w_rb_ok;
    logic [OW-1:0]        w_out_next;
    logic [AW-1:0]        w_addr_step;

    // Burst length: remaining beats, capped by MAX_BURST and distance to the next 4 KB page
    assign w_b4k       = (13'd4096 - {1'b0, r_addr[11:0]}) >> SZ;
    assign w_lim       = (MW'(w_b4k) < MW'(MAX_BURST)) ? MW'(w_b4k) : MW'(MAX_BURST);
    assign w_min       = (MW'(r_rem) < w_lim) ? MW'(r_rem) : w_lim;
    assign w_blen_calc = (w_min == '0) ? 9'd1 : 9'(w_min);

    // FIFO headroom after counting beats already requested but not yet returned
    assign w_space    = $signed(SW'(MAX_DATA_COUNT)) - $signed(SW'(data_count))
                      - $signed(SW'(r_outstanding));
    assign w_space_ok = (w_space >= $signed(SW'(r_blen)));

    assign w_hs        = r_arvalid & M_AXI_ARREADY;
    assign w_spurious  = rbeat & (r_outstanding == '0);
    assign w_rb_ok     = rbeat & ~w_spurious;
    assign w_out_next  = r_outstanding + (w_hs ? OW'(r_blen) : OW'(0))
                       - (w_rb_ok ? OW'(1) : OW'(0));
    assign w_addr_step = AW'(r_blen) << SZ;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_rem         <= '0;
            r_blen        <= '0;
            r_outstanding <= '0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_arvalid     <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
            r_cmd_ready   <= 1'b1;
        end else begin
            r_done        <= 1'b0;
            r_outstanding <= w_out_next;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr <= cmd_addr;
                        r_rem  <= cmd_beats;
                        r_err  <= 1'b0;
                        if (cmd_beats == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= S_CALC;
                            r_busy      <= 1'b1;
                            r_cmd_ready <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_blen  <= w_blen_calc;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Request stays frozen once raised, whatever data_count does
                    if (!r_arvalid) begin
                        if (w_space_ok) begin
                            r_arvalid <= 1'b1;
                            r_araddr  <= r_addr;
                            r_arlen   <= 8'(r_blen - 9'd1);
                        end
                    end else if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_addr    <= r_addr + w_addr_step;
                        r_rem     <= r_rem - LW'(r_blen);
                        r_state   <= (r_rem == LW'(r_blen)) ? S_DRAIN : S_CALC;
                    end
                end
                S_DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // A beat with nothing outstanding is a protocol error; it wins over the clear
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARLEN   = r_arlen;
    assign M_AXI_ARSIZE  = 3'(SZ);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = r_arvalid;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_burst_read_sched.sv
// Scoreboard bench for burst_read_sched: directed corner cases plus randomized commands.
module tb_burst_read_sched;

    localparam int MDC = 256;
    localparam int MB  = 16;
    localparam int BPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_beats = '0;
    logic [8:0]  data_count = '0;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b0;
    logic        rbeat = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    burst_read_sched dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_beats    (cmd_beats),
        .data_count   (data_count),
        .M_AXI_ARADDR (M_AXI_ARADDR),
        .M_AXI_ARLEN  (M_AXI_ARLEN),
        .M_AXI_ARSIZE (M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .rbeat        (rbeat),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [31:0] q_addr[$];
    int          q_len[$];
    int          q_dbeats[$];
    int          q_dcyc[$];
    int          m_out  = 0;
    int          m_left = 0;
    bit          m_err  = 1'b0;

    bit          prev_av = 1'b0, prev_ar = 1'b0, prev_hs = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;
    int          prev_space = 0;

    int rb_mode = 0;
    bit rnd_ar  = 1'b0;
    bit rnd_dc  = 1'b0;

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_eq(input string name, input longint act, input longint req);
        chk(name, act == req, act, req);
    endtask

    // Reference split: each burst is min(remaining, MAX_BURST, beats left in the 4 KB page)
    task automatic push_bursts(input logic [31:0] a, input int n);
        logic [31:0] aa;
        int          b;
        int          to4k;
        aa = a;
        while (n > 0) begin
            to4k = (4096 - int'(aa % 32'd4096)) / BPB;
            b = n;
            if (b > MB) b = MB;
            if (b > to4k) b = to4k;
            q_addr.push_back(aa);
            q_len.push_back(b - 1);
            aa = aa + 32'(b * BPB);
            n -= b;
        end
    endtask

    task automatic monitor();
        bit          hs;
        bit          acc;
        bit          rb_ok;
        logic [31:0] ea;
        int          el;
        int          db;
        int          dcy;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q_addr.delete(); q_len.delete(); q_dbeats.delete(); q_dcyc.delete();
                m_out = 0; m_left = 0; m_err = 1'b0;
                prev_av = 1'b0; prev_ar = 1'b0; prev_hs = 1'b0;
            end else begin
                hs  = M_AXI_ARVALID && M_AXI_ARREADY;
                acc = cmd_valid && cmd_ready;
                chk_eq("err", err, m_err);
                if (prev_hs)
                    chk_eq("arvalid_drop", M_AXI_ARVALID, 0);
                else if (prev_av && !prev_ar)
                    chk("ar_hold", M_AXI_ARVALID && M_AXI_ARADDR == prev_addr && M_AXI_ARLEN == prev_len,
                        M_AXI_ARADDR, prev_addr);
                else if (M_AXI_ARVALID)
                    chk("ar_space", prev_space >= int'(M_AXI_ARLEN) + 1, prev_space, int'(M_AXI_ARLEN) + 1);
                el = -1;
                if (hs) begin
                    if (q_addr.size() == 0) begin
                        chk("ar_unexpected", 1'b0, M_AXI_ARADDR, 0);
                    end else begin
                        ea = q_addr.pop_front();
                        el = q_len.pop_front();
                        chk_eq("araddr", M_AXI_ARADDR, ea);
                        chk_eq("arlen", M_AXI_ARLEN, el);
                    end
                    chk_eq("ar_busy", busy, 1);
                    chk_eq("arsize", M_AXI_ARSIZE, 2);
                    chk_eq("arburst", M_AXI_ARBURST, 1);
                end
                if (done) begin
                    if (q_dbeats.size() == 0) begin
                        chk("done_unexpected", 1'b0, 1, 0);
                    end else begin
                        db  = q_dbeats.pop_front();
                        dcy = q_dcyc.pop_front();
                        if (db == 0) begin
                            chk_eq("done_zero_latency", cyc - dcy, 1);
                        end else begin
                            chk_eq("done_beats_left", m_left, 0);
                            chk_eq("done_ars_left", q_addr.size(), 0);
                            chk_eq("done_busy", busy, 0);
                        end
                    end
                end
                prev_space = MDC - int'(data_count) - m_out;
                if (acc) m_err = 1'b0;
                if (rbeat && m_out == 0) m_err = 1'b1;
                rb_ok = rbeat && (m_out > 0);
                m_out = m_out + el + 1 - (rb_ok ? 1 : 0);
                if (rb_ok) m_left--;
                if (acc) begin
                    push_bursts(cmd_addr, int'(cmd_beats));
                    q_dbeats.push_back(int'(cmd_beats));
                    q_dcyc.push_back(cyc);
                    if (cmd_beats != 0) m_left = int'(cmd_beats);
                end
                prev_av   = M_AXI_ARVALID;
                prev_ar   = M_AXI_ARREADY;
                prev_hs   = hs;
                prev_addr = M_AXI_ARADDR;
                prev_len  = M_AXI_ARLEN;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (rb_mode)
            0:       rbeat = 1'b0;
            1:       rbeat = (m_out > 0);
            default: rbeat = (m_out > 0) && ($urandom_range(0, 1) == 1);
        endcase
        if (rnd_ar) M_AXI_ARREADY = ($urandom_range(0, 2) != 0);
        if (rnd_dc) data_count = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(200, 255))
                                                             : 9'($urandom_range(0, 120));
    endtask

    task automatic send_cmd(input logic [31:0] a, input int n);
        bit ok;
        ok = 1'b0;
        cmd_addr  = a;
        cmd_beats = 16'(n);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) chk("cmd_accept_timeout", 1'b0, 0, 1);
    endtask

    task automatic wait_idle(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            ok = (q_dbeats.size() == 0);
        end
        if (!ok) chk("done_timeout", 1'b0, q_dbeats.size(), 0);
    endtask

    task automatic wait_arvalid();
        bit ok;
        ok = M_AXI_ARVALID;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            ok = M_AXI_ARVALID;
        end
        if (!ok) chk("arvalid_timeout", 1'b0, 0, 1);
    endtask

    initial begin
        logic [31:0] a;
        int          n;
        fork
            monitor();
        join_none

        // Reset values
        #1;
        chk_eq("rst_arvalid", M_AXI_ARVALID, 0);
        chk_eq("rst_araddr", M_AXI_ARADDR, 0);
        chk_eq("rst_arlen", M_AXI_ARLEN, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_err", err, 0);
        chk_eq("rst_arsize", M_AXI_ARSIZE, 2);
        chk_eq("rst_arburst", M_AXI_ARBURST, 1);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk_eq("rst_cmd_ready", cmd_ready, 1);

        // Split by MAX_BURST, then by 4 KB page
        M_AXI_ARREADY = 1'b1; data_count = '0; rb_mode = 1;
        send_cmd(32'h0000_1000, 40);
        wait_idle(500);
        send_cmd(32'h0000_0FF0, 16);
        wait_idle(500);
        send_cmd(32'hFFFF_FFF0, 8);
        wait_idle(500);

        // FIFO headroom gating, then AR held while ARREADY is low
        rb_mode = 0; M_AXI_ARREADY = 1'b0; data_count = 9'd250;
        send_cmd(32'h0000_2000, 16);
        for (int i = 0; i < 6; i++) begin
            chk_eq("space_hold_low", M_AXI_ARVALID, 0);
            tick();
        end
        data_count = 9'd240;
        chk_eq("space_before_rise", M_AXI_ARVALID, 0);
        tick();
        chk_eq("space_rise", M_AXI_ARVALID, 1);
        for (int k = 1; k <= 5; k++) begin
            data_count = 9'(240 + 3 * k);
            chk("stall_stable", M_AXI_ARVALID && M_AXI_ARADDR == 32'h2000 && M_AXI_ARLEN == 8'd15,
                M_AXI_ARADDR, 32'h2000);
            tick();
        end
        M_AXI_ARREADY = 1'b1;
        tick();
        chk_eq("stall_release", M_AXI_ARVALID, 0);
        data_count = '0; rb_mode = 1;
        wait_idle(500);

        // AR handshake coincident with an rbeat, then a spurious rbeat
        rb_mode = 0; M_AXI_ARREADY = 1'b0;
        send_cmd(32'h0000_0FF0, 20);
        wait_arvalid();
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        tick();
        wait_arvalid();
        chk_eq("coinc_len", M_AXI_ARLEN, 15);
        M_AXI_ARREADY = 1'b1;
        rbeat = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        rb_mode = 1;
        wait_idle(500);
        chk_eq("coinc_no_err", err, 0);
        rb_mode = 0;
        rbeat = 1'b1;
        tick();
        chk_eq("spurious_err", err, 1);
        tick();
        chk_eq("spurious_err_sticky", err, 1);

        // Zero-beat command
        send_cmd(32'h0000_5000, 0);
        chk_eq("zero_done", done, 1);
        chk_eq("zero_err_clear", err, 0);
        tick();
        chk_eq("zero_done_one", done, 0);
        wait_idle(50);

        // Reset while a request is pending
        M_AXI_ARREADY = 1'b0;
        send_cmd(32'h0000_6000, 32);
        wait_arvalid();
        #2;
        rst = 1'b1;
        #1;
        chk_eq("midrst_arvalid", M_AXI_ARVALID, 0);
        chk_eq("midrst_busy", busy, 0);
        chk_eq("midrst_araddr", M_AXI_ARADDR, 0);
        tick();
        rst = 1'b0;
        #1;
        chk_eq("midrst_cmd_ready", cmd_ready, 1);
        rbeat = 1'b1;
        tick();
        chk_eq("late_rbeat_err", err, 1);
        tick(); tick();

        // Randomized commands
        rnd_ar = 1'b1; rnd_dc = 1'b1; rb_mode = 2;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom & 32'hFFFF_FFFC;
                1:       a = ($urandom & 32'hFFFF_F000) | (32'h0000_0FC0 + 32'(4 * $urandom_range(0, 15)));
                2:       a = 32'hFFFF_FFF0 - 32'(4 * $urandom_range(0, 3));
                default: a = 32'(4 * $urandom_range(0, 2000));
            endcase
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 70));
            send_cmd(a, n);
            wait_idle(3000);
        end
        rnd_ar = 1'b0; rnd_dc = 1'b0; rb_mode = 0;
        tick(); tick();
        chk_eq("end_ar_queue", q_addr.size(), 0);
        chk_eq("end_done_queue", q_dbeats.size(), 0);
        chk_eq("end_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/burst_read_sched.md
BURST_READ_SCHED -- requirements
Module: burst_read_sched

Interface
REQ-001 The block SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32: AR address width.
REQ-002 The block SHALL have parameter C_M_AXI_DATA_WIDTH, default 32: data width in bits, power of two, 8..1024; bytes per beat BPB = C_M_AXI_DATA_WIDTH/8.
REQ-003 The block SHALL have parameter DATA_COUNT_WIDTH, default 9: width of the consumer FIFO occupancy input.
REQ-004 The block SHALL have parameter MAX_DATA_COUNT, default 256: consumer FIFO depth in beats.
REQ-005 The block SHALL have parameter MAX_BURST, default 16: maximum beats per burst, 1..256.
REQ-006 The block SHALL have parameter LEN_WIDTH, default 16: width of the command beat count.
REQ-007 The block SHALL have these ports, in this order:
- M_AXI_ACLK, in, 1: the single clock; all logic on the rising edge.
- M_AXI_ARESET, in, 1: asynchronous, active-high reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accept.
- cmd_addr, in, C_M_AXI_ADDR_WIDTH: start byte address, BPB-aligned.
- cmd_beats, in, LEN_WIDTH: total beats to read.
- data_count, in, DATA_COUNT_WIDTH: current consumer FIFO occupancy.
- M_AXI_ARADDR, out, C_M_AXI_ADDR_WIDTH: burst address.
- M_AXI_ARLEN, out, 8: burst beats minus 1.
- M_AXI_ARSIZE, out, 3: constant log2(BPB).
- M_AXI_ARBURST, out, 2: constant 2'b01 (INCR).
- M_AXI_ARVALID, out, 1: AR request.
- M_AXI_ARREADY, in, 1: AR accept.
- rbeat, in, 1: R-channel handshake strobe (RVALID & RREADY).
- busy, out, 1: high whenever the state is not IDLE.
- done, out, 1: one-cycle completion pulse.
- err, out, 1: sticky protocol error.

Function
REQ-008 The state machine SHALL have four states: IDLE, CALC, ISSUE and DRAIN.
REQ-009 cmd_ready SHALL equal 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready.
REQ-010 On acceptance, the block SHALL latch addr = cmd_addr and rem = cmd_beats, and clear err.
REQ-011 On acceptance with cmd_beats != 0, the block SHALL go to CALC.
REQ-012 On acceptance with cmd_beats == 0, the block SHALL stay in IDLE and pulse done the next cycle.
REQ-013 In CALC, the block SHALL register blen = min(rem, MAX_BURST, b4k), where b4k = (4096 - addr[11:0]) / BPB, so no burst crosses a 4 KB boundary; it SHALL then go to ISSUE, so CALC lasts exactly 1 cycle.
REQ-014 In ISSUE, the block SHALL compute space = MAX_DATA_COUNT - data_count - outstanding at DATA_COUNT_WIDTH+2 bits signed; a negative value counts as no space.
REQ-015 M_AXI_ARVALID SHALL rise only in ISSUE when space >= blen.
REQ-016 Once M_AXI_ARVALID is high, it and ARADDR/ARLEN SHALL hold stable until M_AXI_ARREADY, regardless of data_count.
REQ-017 M_AXI_ARADDR SHALL equal addr and M_AXI_ARLEN SHALL equal blen-1 while M_AXI_ARVALID is high.
REQ-018 On the AR handshake, the block SHALL apply:
- M_AXI_ARVALID is 0 next cycle.
- outstanding += blen - rbeat.
- addr += blen*BPB.
- rem -= blen.
- next state is CALC if rem != 0, else DRAIN.
REQ-019 outstanding SHALL be a counter of width DATA_COUNT_WIDTH+1 that decrements by 1 on each rbeat in every state.
REQ-020 An AR handshake and an rbeat in the same cycle SHALL apply both updates, giving a net change of blen-1.
REQ-021 In DRAIN, when outstanding == 0, the block SHALL go to IDLE and assert done for exactly 1 cycle on that transition; there is no back-to-back gap beyond this.
REQ-022 If rbeat is high while outstanding == 0, outstanding SHALL stay 0 and err SHALL set; err remains set until the next accepted command or reset.
REQ-023 Address arithmetic SHALL wrap modulo 2^C_M_AXI_ADDR_WIDTH.
REQ-024 The block SHALL never issue ARLEN+1 > MAX_BURST, and SHALL never issue a burst of 0 beats.

Reset
REQ-025 While M_AXI_ARESET is high, the block SHALL asynchronously force:
- state IDLE.
- M_AXI_ARVALID = 0, done = 0, err = 0, busy = 0.
- outstanding = 0, rem = 0, addr = 0, blen = 0.
- M_AXI_ARADDR = 0, M_AXI_ARLEN = 0.
- cmd_ready = 1 after the reset is released.
REQ-026 Reset asserted mid-burst SHALL abandon the command with no done pulse; late rbeats after reset release SHALL set err.

Verification
REQ-027 cmd_addr=0x1000, cmd_beats=40, data_count=0, ARREADY=1, rbeat immediate -> ARs (0x1000, LEN 15), (0x1040, LEN 15), (0x1080, LEN 7); done after the 40th rbeat.
REQ-028 cmd_addr=0x0FF0, cmd_beats=16 -> ARs (0x0FF0, LEN 3), (0x1000, LEN 11); no 4 KB crossing.
REQ-029 data_count=250, outstanding=0, blen=16 -> ARVALID stays 0; drop data_count to 240 -> ARVALID rises the next cycle.
REQ-030 ARREADY low for 5 cycles while data_count rises to 255 -> ARVALID and ARADDR held stable throughout; handshake on cycle 6.
REQ-031 AR handshake with blen=16 coincident with rbeat, outstanding=4 -> outstanding=19; an rbeat with outstanding=0 -> err=1 and outstanding=0.
REQ-032 cmd_beats=0 -> no AR is issued; done pulses one cycle after acceptance. Reset mid-ISSUE -> ARVALID=0 immediately and state IDLE.
